// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the bit-counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // One extra bit so the counter can represent WIDTH itself without wrapping.
    function automatic int cntWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Purely combinational one-bit full adder built from gate primitives;
// the serial adder evaluates one bit slice per clock through this cell.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output wire  s,
    output wire  co
);

    wire halfSum;
    wire genCarry;
    wire propCarry;

    xor gXorAb  (halfSum, a, b);
    xor gXorSum (s, halfSum, ci);
    and gAndGen (genCarry, a, b);
    and gAndPrp (propCarry, halfSum, ci);
    or  gOrCo   (co, propCarry, genCarry);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB first through a single
// full-adder cell with a registered carry, producing a registered sum/cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cntWidth(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] shiftA_q;
    logic [WIDTH-1:0] shiftB_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             cellS;
    logic             cellC;
    logic [WIDTH-1:0] res_d;
    logic             lastBit;
    logic             accept;

    serial_fa_cell uCell (
        .a  (shiftA_q[0]),
        .b  (shiftB_q[0]),
        .ci (carry_q),
        .s  (cellS),
        .co (cellC)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice.
    assign res_d   = WIDTH'({cellS, res_q} >> 1);
    assign lastBit = (cnt_q == CW'(WIDTH - 1));
    assign accept  = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            shiftA_q <= '0;
            shiftB_q <= '0;
            res_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q  <= RUN;
                busy_q   <= 1'b1;
                shiftA_q <= a;
                shiftB_q <= b;
                carry_q  <= cin;
                cnt_q    <= '0;
            end else if (state_q == RUN) begin
                carry_q  <= cellC;
                shiftA_q <= shiftA_q >> 1;
                shiftB_q <= shiftB_q >> 1;
                res_q    <= res_d;
                cnt_q    <= cnt_q + CW'(1);
                if (lastBit) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    sum_q   <= res_d;
                    cout_q  <= cellC;
                end
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random adds on an 8-bit
// instance plus the full truth table on a 1-bit instance, against plain arithmetic.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int assertCount = 0;
    int failCount   = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one add on the 8-bit instance and check the whole busy/done timeline.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string tag);
        logic [8:0] expSum;
        expSum = 9'(av) + 9'(bv) + 9'(cv);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checkOutput({tag, " busy"}, 32'(busy8), 32'd1);
            checkOutput({tag, " early done"}, 32'(done8), 32'd0);
            tick();
        end
        checkOutput({tag, " done"}, 32'(done8), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busy8), 32'd0);
        checkOutput({tag, " sum"}, 32'(sum8), 32'(expSum[7:0]));
        checkOutput({tag, " cout"}, 32'(cout8), 32'(expSum[8]));
        tick();
        checkOutput({tag, " done one cycle"}, 32'(done8), 32'd0);
        checkOutput({tag, " sum held"}, 32'(sum8), 32'(expSum[7:0]));
    endtask

    initial begin
        int pulses;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [1:0] exp1;

        // Reset state of both instances
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset busy8", 32'(busy8), 32'd0);
        checkOutput("reset done8", 32'(done8), 32'd0);
        checkOutput("reset sum8", 32'(sum8), 32'd0);
        checkOutput("reset cout8", 32'(cout8), 32'd0);
        checkOutput("reset busy1", 32'(busy1), 32'd0);
        checkOutput("reset sum1", 32'(sum1), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(8'h35, 8'h0A, 1'b0, "35+0A");
        applyStimulus(8'hFF, 8'h01, 1'b0, "FF+01");
        applyStimulus(8'hFF, 8'hFF, 1'b1, "FF+FF+1");

        // Reset in the middle of an add: abort, clear outputs, no done pulse
        a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset busy", 32'(busy8), 32'd0);
        checkOutput("midreset done", 32'(done8), 32'd0);
        checkOutput("midreset sum", 32'(sum8), 32'd0);
        checkOutput("midreset cout", 32'(cout8), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) pulses++;
            tick();
        end
        checkOutput("midreset stays idle", 32'(pulses), 32'd0);
        applyStimulus(8'h02, 8'h03, 1'b0, "02+03");

        // Start during RUN must be ignored
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 4; i <= 8; i++) begin
            checkOutput("ignore busy", 32'(busy8), 32'd1);
            tick();
        end
        checkOutput("ignore done", 32'(done8), 32'd1);
        checkOutput("ignore sum", 32'(sum8), 32'h30);
        checkOutput("ignore cout", 32'(cout8), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) pulses++;
        end
        checkOutput("ignore single done", 32'(pulses), 32'd0);

        // Back-to-back with start held high; second add accepted in DONE
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        for (int i = 1; i <= 8; i++) begin
            checkOutput("b2b first busy", 32'(busy8), 32'd1);
            tick();
        end
        checkOutput("b2b first done", 32'(done8), 32'd1);
        checkOutput("b2b first sum", 32'(sum8), 32'h10);
        checkOutput("b2b first cout", 32'(cout8), 32'd0);
        tick();
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checkOutput("b2b second busy", 32'(busy8), 32'd1);
            checkOutput("b2b second early done", 32'(done8), 32'd0);
            tick();
        end
        checkOutput("b2b second done", 32'(done8), 32'd1);
        checkOutput("b2b second sum", 32'(sum8), 32'h00);
        checkOutput("b2b second cout", 32'(cout8), 32'd1);
        tick();
        tick();

        // Random operands against plain integer addition
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, $sformatf("rand%0d", n));
        end

        // WIDTH=1 instance: full-adder truth table, done two cycles after start
        for (int v = 0; v < 8; v++) begin
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            exp1 = 2'(v >> 2 & 1) + 2'(v >> 1 & 1) + 2'(v & 1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            checkOutput($sformatf("w1 busy %0d", v), 32'(busy1), 32'd1);
            checkOutput($sformatf("w1 early done %0d", v), 32'(done1), 32'd0);
            tick();
            checkOutput($sformatf("w1 done %0d", v), 32'(done1), 32'd1);
            checkOutput($sformatf("w1 result %0d", v), 32'({cout1, sum1}), 32'(exp1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
